ecc_secded_codec: RTL and testbench
===================================

# ecc_secded_codec

Parametrised, pipelined Hamming SECDED (single-error-correct, double-error-detect) codec for the dual port memory ECC path.
- Encode channel: generates the stored codeword for a write.
- Decode channel: checks a read codeword, corrects single-bit errors, flags double-bit errors and counts both.
- Both channels use valid/ready handshakes with full back-pressure and sustain one word per cycle.

## Interface

Parameters:
- DATA_W, 8, data width (≥ 4).
- P, derived (localparam), smallest integer with 2^P ≥ DATA_W+P+1 (4 for DATA_W=8).
- CW_W, derived, codeword width = DATA_W+P+1 (13 for DATA_W=8).
- POS_W, derived, $clog2(CW_W).
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enc_valid_i  in  1  encode input valid.
- enc_ready_o  out  1  encode input ready.
- enc_data_i  in  DATA_W  data to encode.
- enc_valid_o  out  1  codeword valid.
- enc_ready_i  in  1  codeword consumer ready.
- enc_code_o  out  CW_W  encoded codeword.
- dec_valid_i  in  1  decode input valid.
- dec_ready_o  out  1  decode input ready.
- dec_code_i  in  CW_W  codeword read from memory.
- dec_valid_o  out  1  decoded result valid.
- dec_ready_i  in  1  decode consumer ready.
- dec_data_o  out  DATA_W  corrected data.
- dec_sbe_o  out  1  single-bit error corrected.
- dec_dbe_o  out  1  uncorrectable (double) error.
- dec_err_pos_o  out  POS_W  flipped codeword bit index when dec_sbe_o=1, else 0.
- cnt_clr_i  in  1  synchronous clear of both counters.
- sbe_cnt_o  out  CNT_W  corrected-error count, saturating.
- dbe_cnt_o  out  CNT_W  uncorrectable-error count, saturating.

## Operation

- Codeword layout:
  - Bits 1..CW_W-1 are Hamming positions.
  - Check bits sit at power-of-two positions (1, 2, 4, 8, ...).
  - Check bit at position 2^k = XOR of all positions with address bit k set.
  - Data bits fill the remaining positions in ascending order, data bit 0 at position 3.
  - Bit 0 = overall even parity = XOR of bits 1..CW_W-1.
- Encode: compute the codeword from enc_data_i and register it into a single output stage.
- Decode stage 1 registers:
  - syndrome S (P bits) = XOR of the addresses of all set bits in positions 1..CW_W-1.
  - overall parity error E = XOR of all CW_W bits.
  - the raw codeword.
- Decode stage 2 classifies and registers the result:
  - S=0, E=0: clean. Data extracted unchanged, sbe=0, dbe=0, pos=0.
  - E=1: single error at position S (S=0 means bit 0). Flip that bit, extract data, sbe=1, pos=S.
  - S≠0, E=0: double error. Data extracted uncorrected, dbe=1, pos=0.
  - E=1 with S ≥ CW_W: treat as dbe=1, no flip.
- Counters:
  - increment on dec_valid_o && dec_ready_i when sbe (or dbe) is set; a stalled result is counted exactly once.
  - saturate at all-ones.
  - cnt_clr_i has priority over a same-cycle increment (result 0).

## Timing

- Reset: all valids 0, all data/code/status outputs 0, counters 0. Asynchronous assert; in-flight words are discarded.
- Handshake rules:
  - Transfer occurs when valid && ready.
  - valid and payload hold stable while ready=0.
  - Each stage loads when empty or when its content is being consumed that cycle.
  - enc_ready_o = !enc_valid_o || enc_ready_i.
  - dec_ready_o = !s1_valid || s2 can accept, where s2 can accept = !dec_valid_o || dec_ready_i.
  - Combinational ready path is allowed; no combinational valid or data path from input to output.
- Latency: encode 1 cycle, decode 2 cycles, input accept to output valid.
- Throughput: 1 word/cycle per channel with ready held high; no bubbles.
- Channels are fully independent; simultaneous encode and decode traffic is legal.

## Test plan

- Encode 0xA5 (DATA_W=8) → enc_code_o=0x144E one cycle after accept; decode 0x144E → data 0xA5, sbe=0, dbe=0 two cycles after accept.
- Decode 0x140E (bit 6 flipped) → data 0xA5, sbe=1, pos=6, sbe_cnt 0→1. Decode 0x144F (bit 0 flipped) → data 0xA5, sbe=1, pos=0.
- Decode 0x1406 (bits 6 and 3 flipped) → dbe=1, sbe=0, pos=0, dbe_cnt increments by exactly 1.
- Stream 8 words with dec_ready_i toggling every other cycle → outputs in order, none lost or duplicated, stalled outputs stable, each error counted once. Repeat with ready held high → dec_ready_o stays 1 and 8 outputs arrive on consecutive cycles.
- Counter set: preload to saturation via 2^CNT_W-1 errors (CNT_W=4 build) → holds at 0xF. cnt_clr_i asserted with a concurrent sbe → counter reads 0.
- rst_n asserted with both pipelines full → all valids and counters 0 immediately. After release, the first new word decodes correctly.

Source files
------------

// File: rtl/ecc_secded_codec.sv
// Pipelined Hamming SECDED codec: a one-stage encoder and a two-stage
// decoder (syndrome/parity, then classify/correct), each with a valid/ready
// handshake, plus saturating corrected/uncorrectable error counters.
module ecc_secded_codec #(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int P      = $clog2(DATA_W + $clog2(DATA_W) + 1),
    localparam int CW_W   = DATA_W + P + 1,
    localparam int POS_W  = $clog2(CW_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_valid_i,
    output logic              enc_ready_o,
    input  logic [DATA_W-1:0] enc_data_i,
    output logic              enc_valid_o,
    input  logic              enc_ready_i,
    output logic [CW_W-1:0]   enc_code_o,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [CW_W-1:0]   dec_code_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [DATA_W-1:0] dec_data_o,
    output logic              dec_sbe_o,
    output logic              dec_dbe_o,
    output logic [POS_W-1:0]  dec_err_pos_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  sbe_cnt_o,
    output logic [CNT_W-1:0]  dbe_cnt_o
);

    localparam logic [P:0]       CW_LIM  = (P + 1)'(CW_W);
    localparam logic [CW_W-1:0]  CW_ONE  = {{(CW_W - 1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Power-of-two Hamming positions hold check bits; the rest hold data.
    function automatic logic is_check_pos(input int pos);
        return ((pos & (pos - 1)) == 0);
    endfunction

    // Data into ascending non-check positions, check bits, then overall parity in bit 0.
    function automatic logic [CW_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
        logic [CW_W-1:0] cw;
        int              di;
        cw = '0;
        di = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if (!is_check_pos(pos)) begin
                cw[pos] = data[di];
                di      = di + 1;
            end
        end
        for (int k = 0; k < P; k++) begin
            for (int pos = 1; pos < CW_W; pos++) begin
                if (((pos & (1 << k)) != 0) && !is_check_pos(pos)) begin
                    cw[1 << k] = cw[1 << k] ^ cw[pos];
                end
            end
        end
        cw[0] = ^cw[CW_W-1:1];
        return cw;
    endfunction

    // XOR of the addresses of every set bit in positions 1..CW_W-1.
    function automatic logic [P-1:0] hamming_syndrome(input logic [CW_W-1:0] cw);
        logic [P-1:0] syn;
        syn = '0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if (cw[pos]) begin
                syn = syn ^ P'(pos);
            end
        end
        return syn;
    endfunction

    // Pull the data bits back out of the non-check positions.
    function automatic logic [DATA_W-1:0] hamming_extract(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] data;
        int                di;
        data = '0;
        di   = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if (!is_check_pos(pos)) begin
                data[di] = cw[pos];
                di       = di + 1;
            end
        end
        return data;
    endfunction

    logic              enc_valid_q;
    logic [CW_W-1:0]   enc_code_q, enc_code_d;
    logic              s1_valid_q;
    logic [P-1:0]      s1_syn_q, s1_syn_d;
    logic              s1_par_q, s1_par_d;
    logic [CW_W-1:0]   s1_code_q;
    logic              dec_valid_q;
    logic [DATA_W-1:0] dec_data_q, dec_data_d;
    logic              dec_sbe_q, dec_sbe_d;
    logic              dec_dbe_q, dec_dbe_d;
    logic [POS_W-1:0]  dec_pos_q, dec_pos_d;
    logic [CNT_W-1:0]  sbe_cnt_q, sbe_cnt_d;
    logic [CNT_W-1:0]  dbe_cnt_q, dbe_cnt_d;
    logic              enc_load_s, s1_load_s, s2_accept_s, dec_xfer_s;

    assign enc_ready_o   = !enc_valid_q || enc_ready_i;
    assign enc_load_s    = enc_valid_i && enc_ready_o;
    assign s2_accept_s   = !dec_valid_q || dec_ready_i;
    assign dec_ready_o   = !s1_valid_q || s2_accept_s;
    assign s1_load_s     = dec_valid_i && dec_ready_o;
    assign dec_xfer_s    = dec_valid_q && dec_ready_i;

    assign enc_valid_o   = enc_valid_q;
    assign enc_code_o    = enc_code_q;
    assign dec_valid_o   = dec_valid_q;
    assign dec_data_o    = dec_data_q;
    assign dec_sbe_o     = dec_sbe_q;
    assign dec_dbe_o     = dec_dbe_q;
    assign dec_err_pos_o = dec_pos_q;
    assign sbe_cnt_o     = sbe_cnt_q;
    assign dbe_cnt_o     = dbe_cnt_q;

    // Encoder and decode stage-1 next values straight from the inputs.
    always_comb begin
        enc_code_d = hamming_encode(enc_data_i);
        s1_syn_d   = hamming_syndrome(dec_code_i);
        s1_par_d   = ^dec_code_i;
    end

    // Stage-2 classification: clean, correctable (E=1, S in range) or uncorrectable.
    always_comb begin
        dec_data_d = hamming_extract(s1_code_q);
        dec_sbe_d  = 1'b0;
        dec_dbe_d  = 1'b0;
        dec_pos_d  = '0;
        if (s1_par_q) begin
            if ({1'b0, s1_syn_q} >= CW_LIM) begin
                dec_dbe_d = 1'b1;
            end else begin
                dec_data_d = hamming_extract(s1_code_q ^ (CW_ONE << s1_syn_q));
                dec_sbe_d  = 1'b1;
                dec_pos_d  = POS_W'(s1_syn_q);
            end
        end else if (s1_syn_q != '0) begin
            dec_dbe_d = 1'b1;
        end else begin
            dec_dbe_d = 1'b0;
        end
    end

    // Saturating counters; clear wins over a same-cycle increment.
    always_comb begin
        sbe_cnt_d = sbe_cnt_q;
        dbe_cnt_d = dbe_cnt_q;
        if (cnt_clr_i) begin
            sbe_cnt_d = '0;
            dbe_cnt_d = '0;
        end else begin
            if (dec_xfer_s && dec_sbe_q && (sbe_cnt_q != CNT_MAX)) begin
                sbe_cnt_d = sbe_cnt_q + CNT_ONE;
            end else begin
                sbe_cnt_d = sbe_cnt_q;
            end
            if (dec_xfer_s && dec_dbe_q && (dbe_cnt_q != CNT_MAX)) begin
                dbe_cnt_d = dbe_cnt_q + CNT_ONE;
            end else begin
                dbe_cnt_d = dbe_cnt_q;
            end
        end
    end

    // Encode output stage: load on accept, drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_valid_q <= 1'b0;
            enc_code_q  <= '0;
        end else if (enc_load_s) begin
            enc_valid_q <= 1'b1;
            enc_code_q  <= enc_code_d;
        end else if (enc_ready_i) begin
            enc_valid_q <= 1'b0;
        end
    end

    // Decode stage 1: capture syndrome, overall parity and raw codeword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
            s1_code_q  <= '0;
        end else if (s1_load_s) begin
            s1_valid_q <= 1'b1;
            s1_syn_q   <= s1_syn_d;
            s1_par_q   <= s1_par_d;
            s1_code_q  <= dec_code_i;
        end else if (s2_accept_s) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Decode stage 2: result register, advances whenever it can accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid_q <= 1'b0;
            dec_data_q  <= '0;
            dec_sbe_q   <= 1'b0;
            dec_dbe_q   <= 1'b0;
            dec_pos_q   <= '0;
        end else if (s2_accept_s) begin
            dec_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                dec_data_q <= dec_data_d;
                dec_sbe_q  <= dec_sbe_d;
                dec_dbe_q  <= dec_dbe_d;
                dec_pos_q  <= dec_pos_d;
            end
        end
    end

    // Error counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbe_cnt_q <= '0;
            dbe_cnt_q <= '0;
        end else begin
            sbe_cnt_q <= sbe_cnt_d;
            dbe_cnt_q <= dbe_cnt_d;
        end
    end

endmodule

// File: tb/tb_ecc_secded_codec.sv
// Self-checking bench for ecc_secded_codec (DATA_W=8). A second instance with
// 4-bit counters shares the decode stimulus so saturation is reachable quickly.
module tb_ecc_secded_codec;
    localparam int CW = 13;
    localparam int PB = 4;

    typedef struct {
        logic [7:0] d;
        logic       sbe;
        logic       dbe;
        logic [3:0] pos;
    } dexp_t;

    logic        clk, rst_n;
    logic        enc_valid_i, enc_ready_o, enc_valid_o, enc_ready_i;
    logic [7:0]  enc_data_i;
    logic [12:0] enc_code_o;
    logic        dec_valid_i, dec_ready_o, dec_valid_o, dec_ready_i;
    logic [12:0] dec_code_i;
    logic [7:0]  dec_data_o;
    logic        dec_sbe_o, dec_dbe_o;
    logic [3:0]  dec_err_pos_o;
    logic        cnt_clr_i;
    logic [15:0] sbe_cnt_o, dbe_cnt_o;
    logic        n_enc_ready, n_enc_valid, n_dec_ready, n_dec_valid, n_sbe, n_dbe;
    logic [12:0] n_enc_code;
    logic [7:0]  n_dec_data;
    logic [3:0]  n_pos, n_sbe_cnt, n_dbe_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [12:0] enc_q[$];
    dexp_t       dec_q[$];
    int          m_sbe16, m_dbe16, m_sbe4, m_dbe4;
    bit          enc_hold, dec_hold, enc_acc, dec_acc, dec_xfer, dec_rdy_seen;
    logic [12:0] enc_hold_code;
    dexp_t       dec_hold_val;
    int          dec_out_cnt = 0;
    int          sent, got0, nout;
    logic [12:0] words[8];
    logic [12:0] w;

    ecc_secded_codec #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .enc_valid_i(enc_valid_i), .enc_ready_o(enc_ready_o), .enc_data_i(enc_data_i),
        .enc_valid_o(enc_valid_o), .enc_ready_i(enc_ready_i), .enc_code_o(enc_code_o),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_code_i(dec_code_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .dec_data_o(dec_data_o),
        .dec_sbe_o(dec_sbe_o), .dec_dbe_o(dec_dbe_o), .dec_err_pos_o(dec_err_pos_o),
        .cnt_clr_i(cnt_clr_i), .sbe_cnt_o(sbe_cnt_o), .dbe_cnt_o(dbe_cnt_o)
    );

    ecc_secded_codec #(.DATA_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .enc_valid_i(1'b0), .enc_ready_o(n_enc_ready), .enc_data_i(8'h00),
        .enc_valid_o(n_enc_valid), .enc_ready_i(1'b1), .enc_code_o(n_enc_code),
        .dec_valid_i(dec_valid_i), .dec_ready_o(n_dec_ready), .dec_code_i(dec_code_i),
        .dec_valid_o(n_dec_valid), .dec_ready_i(dec_ready_i), .dec_data_o(n_dec_data),
        .dec_sbe_o(n_sbe), .dec_dbe_o(n_dbe), .dec_err_pos_o(n_pos),
        .cnt_clr_i(cnt_clr_i), .sbe_cnt_o(n_sbe_cnt), .dbe_cnt_o(n_dbe_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (from the codeword rules) ----------------
    function automatic bit is_pow2(int n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    // Check bit k = bit k of the XOR of addresses of all set data positions.
    function automatic logic [12:0] m_encode(logic [7:0] d);
        logic [12:0] cw;
        int          ax, di;
        cw = 13'h0; ax = 0; di = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if (!is_pow2(pos)) begin
                if (d[di]) begin
                    cw[pos] = 1'b1;
                    ax = ax ^ pos;
                end
                di++;
            end
        end
        for (int k = 0; k < PB; k++) cw[1 << k] = ax[k];
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic logic [7:0] m_extract(logic [12:0] cw);
        logic [7:0] d;
        int         di;
        d = 8'h00; di = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if (!is_pow2(pos)) begin
                d[di] = cw[pos];
                di++;
            end
        end
        return d;
    endfunction

    function automatic bit m_is_code(logic [12:0] cw);
        return m_encode(m_extract(cw)) == cw;
    endfunction

    // Brute force: valid word, or the unique single flip that makes it valid, else uncorrectable.
    function automatic dexp_t m_decode(logic [12:0] cw);
        dexp_t       r;
        logic [12:0] t;
        r.d = m_extract(cw); r.sbe = 1'b0; r.dbe = 1'b0; r.pos = 4'd0;
        if (m_is_code(cw)) return r;
        for (int j = 0; j < CW; j++) begin
            t = cw;
            t[j] = ~t[j];
            if (m_is_code(t)) begin
                r.d = m_extract(t); r.sbe = 1'b1; r.pos = 4'(j);
                return r;
            end
        end
        r.dbe = 1'b1;
        return r;
    endfunction

    // Random codeword with 0..3 distinct bit flips.
    function automatic logic [12:0] gen_word(int nflip);
        logic [12:0] cw, mask;
        cw = m_encode(8'($urandom));
        mask = 13'h0;
        while ($countones(mask) < nflip) mask[$urandom_range(0, CW - 1)] = 1'b1;
        return cw ^ mask;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check holds and transfers before the edge, update model after it.
    task automatic step();
        bit    enc_out, dec_out, clr;
        dexp_t e;
        #1;
        enc_acc      = enc_valid_i && enc_ready_o;
        dec_acc      = dec_valid_i && dec_ready_o;
        enc_out      = enc_valid_o && enc_ready_i;
        dec_out      = dec_valid_o && dec_ready_i;
        dec_rdy_seen = dec_ready_o;
        clr          = cnt_clr_i;
        if (enc_hold) begin
            chk("enc_hold_valid", enc_valid_o, 1'b1);
            chk("enc_hold_code", enc_code_o, enc_hold_code);
        end
        if (dec_hold) begin
            chk("dec_hold_valid", dec_valid_o, 1'b1);
            chk("dec_hold_data", dec_data_o, dec_hold_val.d);
            chk("dec_hold_flags", {dec_sbe_o, dec_dbe_o, dec_err_pos_o},
                {dec_hold_val.sbe, dec_hold_val.dbe, dec_hold_val.pos});
        end
        if (enc_out) begin
            chk("enc_out_expected", enc_q.size() > 0, 1'b1);
            if (enc_q.size() > 0) chk("enc_code", enc_code_o, enc_q.pop_front());
        end
        e.sbe = 1'b0; e.dbe = 1'b0;
        if (dec_out) begin
            dec_out_cnt++;
            chk("dec_out_expected", dec_q.size() > 0, 1'b1);
            if (dec_q.size() > 0) begin
                e = dec_q.pop_front();
                chk("dec_data", dec_data_o, e.d);
                chk("dec_flags", {dec_sbe_o, dec_dbe_o, dec_err_pos_o}, {e.sbe, e.dbe, e.pos});
            end
        end
        dec_xfer = dec_out;
        enc_hold = enc_valid_o && !enc_ready_i;
        enc_hold_code = enc_code_o;
        dec_hold = dec_valid_o && !dec_ready_i;
        dec_hold_val.d = dec_data_o;
        dec_hold_val.sbe = dec_sbe_o; dec_hold_val.dbe = dec_dbe_o; dec_hold_val.pos = dec_err_pos_o;
        if (enc_acc) enc_q.push_back(m_encode(enc_data_i));
        if (dec_acc) dec_q.push_back(m_decode(dec_code_i));
        @(posedge clk);
        #1;
        if (clr) begin
            m_sbe16 = 0; m_dbe16 = 0; m_sbe4 = 0; m_dbe4 = 0;
        end else begin
            if (e.sbe && m_sbe16 < 65535) m_sbe16++;
            if (e.dbe && m_dbe16 < 65535) m_dbe16++;
            if (e.sbe && m_sbe4 < 15) m_sbe4++;
            if (e.dbe && m_dbe4 < 15) m_dbe4++;
        end
        chk("sbe_cnt", sbe_cnt_o, m_sbe16);
        chk("dbe_cnt", dbe_cnt_o, m_dbe16);
        chk("sbe_cnt4", n_sbe_cnt, m_sbe4);
        chk("dbe_cnt4", n_dbe_cnt, m_dbe4);
    endtask

    // Single decode into an empty pipeline with explicit 2-cycle latency checks.
    task automatic dec_one(input logic [12:0] code, input logic [7:0] xd, input logic xs,
                           input logic xb, input logic [3:0] xp);
        dec_ready_i = 1'b1; dec_valid_i = 1'b1; dec_code_i = code;
        step();
        dec_valid_i = 1'b0;
        chk("dec_lat1_valid", dec_valid_o, 1'b0);
        step();
        chk("dec_lat2_valid", dec_valid_o, 1'b1);
        chk("dec_one_data", dec_data_o, xd);
        chk("dec_one_flags", {dec_sbe_o, dec_dbe_o, dec_err_pos_o}, {xs, xb, xp});
        step();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; cnt_clr_i = 1'b0;
        enc_valid_i = 1'b0; enc_ready_i = 1'b1; enc_data_i = 8'h00;
        dec_valid_i = 1'b0; dec_ready_i = 1'b1; dec_code_i = 13'h0;
        m_sbe16 = 0; m_dbe16 = 0; m_sbe4 = 0; m_dbe4 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enc_valid", enc_valid_o, 1'b0);
        chk("rst_dec_valid", dec_valid_o, 1'b0);
        chk("rst_cnts", {sbe_cnt_o, dbe_cnt_o}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_enc_ready", enc_ready_o, 1'b1);
        chk("idle_dec_ready", dec_ready_o, 1'b1);

        // Encode 0xA5: one cycle to valid.
        enc_valid_i = 1'b1; enc_data_i = 8'hA5;
        step();
        enc_valid_i = 1'b0;
        chk("enc_lat_valid", enc_valid_o, 1'b1);
        chk("enc_a5_code", enc_code_o, 13'h144E);
        step();

        // Clean, single (bit 6, bit 0), double, and E=1 with out-of-range syndrome.
        dec_one(13'h144E, 8'hA5, 1'b0, 1'b0, 4'd0);
        chk("sbe_cnt_zero", sbe_cnt_o, 16'd0);
        dec_one(13'h140E, 8'hA5, 1'b1, 1'b0, 4'd6);
        chk("sbe_cnt_one", sbe_cnt_o, 16'd1);
        dec_one(13'h144F, 8'hA5, 1'b1, 1'b0, 4'd0);
        dec_one(13'h1406, 8'hA0, 1'b0, 1'b1, 4'd0);
        chk("dbe_cnt_one", dbe_cnt_o, 16'd1);
        dec_one(13'h044D, 8'h25, 1'b0, 1'b1, 4'd0);

        // 8 words with consumer ready toggling.
        for (int i = 0; i < 8; i++) words[i] = gen_word(i % 4);
        sent = 0; got0 = dec_out_cnt;
        for (int cyc = 0; cyc < 100 && (dec_out_cnt - got0) < 8; cyc++) begin
            dec_valid_i = (sent < 8);
            if (sent < 8) dec_code_i = words[sent];
            dec_ready_i = (cyc % 2 == 0);
            step();
            if (dec_acc) sent++;
        end
        dec_valid_i = 1'b0; dec_ready_i = 1'b1;
        chk("toggle_out_count", dec_out_cnt - got0, 8);
        chk("toggle_q_empty", dec_q.size(), 0);

        // 8 words back to back with ready high: no bubbles.
        for (int i = 0; i < 8; i++) words[i] = gen_word($urandom_range(0, 3));
        got0 = dec_out_cnt; nout = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            dec_valid_i = (cyc < 8);
            if (cyc < 8) dec_code_i = words[cyc];
            step();
            chk("stream_ready", dec_rdy_seen, 1'b1);
            if (cyc >= 2) chk("stream_no_bubble", dec_xfer, 1'b1);
        end
        dec_valid_i = 1'b0;
        chk("stream_out_count", dec_out_cnt - got0, 8);

        // Random concurrent traffic on both channels.
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!enc_valid_i || enc_acc) begin
                enc_valid_i = 1'($urandom_range(0, 1));
                enc_data_i = 8'($urandom);
            end
            if (!dec_valid_i || dec_acc) begin
                dec_valid_i = 1'($urandom_range(0, 1));
                dec_code_i = gen_word($urandom_range(0, 3));
            end
            enc_ready_i = ($urandom_range(0, 3) != 0);
            dec_ready_i = ($urandom_range(0, 3) != 0);
            cnt_clr_i = ($urandom_range(0, 63) == 0);
            step();
        end
        enc_valid_i = 1'b0; dec_valid_i = 1'b0; cnt_clr_i = 1'b0;
        enc_ready_i = 1'b1; dec_ready_i = 1'b1;
        repeat (3) step();
        chk("rand_enc_q_empty", enc_q.size(), 0);
        chk("rand_dec_q_empty", dec_q.size(), 0);

        // Saturation of the 4-bit counter build.
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dec_valid_i = 1'b1;
            dec_code_i = gen_word(1);
            step();
        end
        dec_valid_i = 1'b0;
        repeat (3) step();
        chk("sat_sbe_cnt4", n_sbe_cnt, 4'hF);
        chk("sat_sbe_cnt16", sbe_cnt_o, 16'd16);

        // Clear coincides with an sbe transfer: clear wins.
        dec_valid_i = 1'b1; dec_code_i = 13'h140E;
        step();
        dec_valid_i = 1'b0;
        step();
        got0 = dec_out_cnt;
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        chk("clr_xfer_happened", dec_out_cnt - got0, 1);
        chk("clr_sbe_cnt", sbe_cnt_o, 16'd0);
        chk("clr_sbe_cnt4", n_sbe_cnt, 4'd0);
        dec_one(13'h140E, 8'hA5, 1'b1, 1'b0, 4'd6);
        chk("pre_rst_sbe_cnt", sbe_cnt_o, 16'd1);

        // Fill both pipelines, then reset asynchronously.
        enc_valid_i = 1'b1; enc_data_i = 8'h3C; enc_ready_i = 1'b0;
        dec_valid_i = 1'b1; dec_code_i = 13'h144F; dec_ready_i = 1'b0;
        repeat (3) step();
        chk("full_enc_valid", enc_valid_o, 1'b1);
        chk("full_dec_valid", dec_valid_o, 1'b1);
        chk("full_dec_ready", dec_ready_o, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_valids", {enc_valid_o, dec_valid_o}, 2'b00);
        chk("arst_cnts", {sbe_cnt_o, dbe_cnt_o}, 32'h0);
        chk("arst_payload", {enc_code_o, dec_data_o, dec_sbe_o, dec_dbe_o, dec_err_pos_o}, 28'h0);
        enc_q.delete(); dec_q.delete();
        enc_hold = 1'b0; dec_hold = 1'b0;
        m_sbe16 = 0; m_dbe16 = 0; m_sbe4 = 0; m_dbe4 = 0;
        enc_valid_i = 1'b0; dec_valid_i = 1'b0; enc_ready_i = 1'b1; dec_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        dec_one(13'h140E, 8'hA5, 1'b1, 1'b0, 4'd6);
        chk("post_rst_sbe_cnt", sbe_cnt_o, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
